pq_head_ctrl: RTL and testbench

- Front-end controller for the systolic array priority queue; drives the n-1 command interface of cell 0.
- Accepts push/pop/drop requests from a client on a valid/ready channel and serialises them into single-cycle cell strobes.
- Waits for the cell's completion valid, then returns a result/status on a valid/ready response channel.
- Guards empty/full using cell 0 peek-valid and the tail cell's full flag; a watchdog recovers from a missing completion.

---
 rtl/pq_head_ctrl.sv | 171 +++++++++++++++++
 tb/tb_pq_head_ctrl.sv | 381 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pq_head_ctrl.sv
// Head controller for the systolic priority queue.
// Takes push/pop/drop requests from a client and turns each one into a
// single-cycle strobe on cell 0. It then waits for the matching completion
// from the cell and returns a response with a status code.
// Empty and full requests are answered locally and never reach the array.
// A watchdog turns a completion that never arrives into an ERR response.

package pq_pkg;
  localparam int CELL_TW = 16;

  typedef struct packed {
    logic [CELL_TW-1:0] data;
    logic [CELL_TW-1:0] id;
  } cell_t;
endpackage

module pq_head_ctrl #(
  parameter int TW      = 16,
  parameter int TIMEOUT = 64
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          req_valid_i,
  output logic          req_ready_o,
  input  logic [1:0]    req_op_i,
  input  logic [TW-1:0] req_data_i,
  input  logic [TW-1:0] req_id_i,
  output logic          rsp_valid_o,
  input  logic          rsp_ready_i,
  output logic [TW-1:0] rsp_data_o,
  output logic [TW-1:0] rsp_id_o,
  output logic [1:0]    rsp_status_o,
  input  logic          peek_vld_i,
  input  logic [TW-1:0] peek_data_i,
  input  logic          full_i,
  output logic          push_o,
  output logic          pop_o,
  output logic          drop_o,
  output logic [TW-1:0] drop_id_o,
  output pq_pkg::cell_t push_struct_o,
  input  logic          push_vld_i,
  input  logic          pop_vld_i,
  input  logic          drop_vld_i,
  input  pq_pkg::cell_t pop_struct_i
);

  localparam int TMR_W = $clog2(TIMEOUT);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

  localparam logic [1:0] ST_OK    = 2'b00;
  localparam logic [1:0] ST_EMPTY = 2'b01;
  localparam logic [1:0] ST_FULL  = 2'b10;
  localparam logic [1:0] ST_ERR   = 2'b11;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  typedef enum logic [1:0] {
    OP_PUSH = 2'b00,
    OP_POP  = 2'b01,
    OP_DROP = 2'b10,
    OP_ILL  = 2'b11
  } op_t;

  state_t           state;
  op_t              op;
  logic [TMR_W-1:0] timer;
  logic             match;

  // The peek data is informational only; it is reduced here so that it is
  // visibly consumed without affecting any decision.
  logic unused_peek;
  assign unused_peek = ^peek_data_i;

  // Only the completion that belongs to the outstanding op counts.
  assign match = ((op == OP_PUSH) && push_vld_i) ||
                 ((op == OP_POP)  && pop_vld_i)  ||
                 ((op == OP_DROP) && drop_vld_i);

  // The whole controller is one registered FSM. Every output is a flop.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state         <= IDLE;
      op            <= OP_PUSH;
      timer         <= '0;
      req_ready_o   <= 1'b0;
      rsp_valid_o   <= 1'b0;
      rsp_data_o    <= '0;
      rsp_id_o      <= '0;
      rsp_status_o  <= ST_OK;
      push_o        <= 1'b0;
      pop_o         <= 1'b0;
      drop_o        <= 1'b0;
      drop_id_o     <= '0;
      push_struct_o <= '0;
    end else begin
      push_o <= 1'b0;
      pop_o  <= 1'b0;
      drop_o <= 1'b0;
      unique case (state)
        IDLE: begin
          if (req_valid_i && req_ready_o) begin
            req_ready_o <= 1'b0;
            op          <= op_t'(req_op_i);
            if (req_op_i == OP_ILL) begin
              state        <= RESP;
              rsp_valid_o  <= 1'b1;
              rsp_status_o <= ST_ERR;
            end else if ((req_op_i == OP_PUSH) && full_i) begin
              state        <= RESP;
              rsp_valid_o  <= 1'b1;
              rsp_status_o <= ST_FULL;
            end else if ((req_op_i == OP_POP) && !peek_vld_i) begin
              state        <= RESP;
              rsp_valid_o  <= 1'b1;
              rsp_status_o <= ST_EMPTY;
            end else begin
              state              <= ISSUE;
              push_o             <= (req_op_i == OP_PUSH);
              pop_o              <= (req_op_i == OP_POP);
              drop_o             <= (req_op_i == OP_DROP);
              push_struct_o.data <= req_data_i;
              push_struct_o.id   <= req_id_i;
              drop_id_o          <= req_id_i;
            end
          end else begin
            req_ready_o <= 1'b1;
          end
        end
        ISSUE: begin
          timer <= '0;
          state <= WAIT;
        end
        WAIT: begin
          if (match || (timer == TMR_LAST)) begin
            state         <= RESP;
            rsp_valid_o   <= 1'b1;
            push_struct_o <= '0;
            drop_id_o     <= '0;
            if (match) begin
              rsp_status_o <= ST_OK;
              if (op == OP_POP) begin
                rsp_data_o <= pop_struct_i.data;
                rsp_id_o   <= pop_struct_i.id;
              end else begin
                rsp_data_o <= '0;
                rsp_id_o   <= '0;
              end
            end else begin
              rsp_status_o <= ST_ERR;
              rsp_data_o   <= '0;
              rsp_id_o     <= '0;
            end
          end else begin
            timer <= timer + 1'b1;
          end
        end
        RESP: begin
          if (rsp_ready_i) begin
            state        <= IDLE;
            rsp_valid_o  <= 1'b0;
            rsp_data_o   <= '0;
            rsp_id_o     <= '0;
            rsp_status_o <= ST_OK;
            req_ready_o  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pq_head_ctrl.sv
// Directed testbench for pq_head_ctrl.
// Runs the controller with a short watchdog. Each task drives one scenario
// and compares the outputs against values worked out by hand.

module tb_pq_head_ctrl;

  localparam int TW      = 16;
  localparam int TIMEOUT = 8;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          req_valid_i;
  logic          req_ready_o;
  logic [1:0]    req_op_i;
  logic [TW-1:0] req_data_i;
  logic [TW-1:0] req_id_i;
  logic          rsp_valid_o;
  logic          rsp_ready_i;
  logic [TW-1:0] rsp_data_o;
  logic [TW-1:0] rsp_id_o;
  logic [1:0]    rsp_status_o;
  logic          peek_vld_i;
  logic [TW-1:0] peek_data_i;
  logic          full_i;
  logic          push_o;
  logic          pop_o;
  logic          drop_o;
  logic [TW-1:0] drop_id_o;
  pq_pkg::cell_t push_struct_o;
  logic          push_vld_i;
  logic          pop_vld_i;
  logic          drop_vld_i;
  pq_pkg::cell_t pop_struct_i;

  int checks   = 0;
  int failures = 0;

  pq_head_ctrl #(.TW(TW), .TIMEOUT(TIMEOUT)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_op_i(req_op_i), .req_data_i(req_data_i), .req_id_i(req_id_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
    .rsp_data_o(rsp_data_o), .rsp_id_o(rsp_id_o), .rsp_status_o(rsp_status_o),
    .peek_vld_i(peek_vld_i), .peek_data_i(peek_data_i), .full_i(full_i),
    .push_o(push_o), .pop_o(pop_o), .drop_o(drop_o), .drop_id_o(drop_id_o),
    .push_struct_o(push_struct_o),
    .push_vld_i(push_vld_i), .pop_vld_i(pop_vld_i), .drop_vld_i(drop_vld_i),
    .pop_struct_i(pop_struct_i)
  );

  always #5 clk_i = ~clk_i;

  // Advance one cycle. Inputs change and outputs are sampled 1 time unit
  // after the rising edge.
  task automatic tick;
    @(posedge clk_i);
    #1;
  endtask

  // Present a request for exactly one cycle. On return the bench is in the
  // cycle after acceptance.
  task automatic send(input logic [1:0] op, input logic [TW-1:0] d, input logic [TW-1:0] i);
    req_valid_i = 1'b1;
    req_op_i    = op;
    req_data_i  = d;
    req_id_i    = i;
    tick();
    req_valid_i = 1'b0;
    req_data_i  = '0;
    req_id_i    = '0;
  endtask

  // Complete a response handshake. On return the bench is in the cycle after it.
  task automatic handshake;
    rsp_ready_i = 1'b1;
    tick();
    rsp_ready_i = 1'b0;
  endtask

  task automatic test_reset;
    rst_i = 1'b1;
    tick();
    tick();
    checks++;
    if ({req_ready_o, rsp_valid_o, push_o, pop_o, drop_o, rsp_status_o} !== 7'b0 ||
        rsp_data_o !== 16'd0 || rsp_id_o !== 16'd0 || drop_id_o !== 16'd0 || push_struct_o !== 32'd0) begin
      failures++;
      $display("[TB] FAIL reset_outputs: got rdy=%b vld=%b strobes=%b%b%b st=%b data=%h id=%h dropid=%h ps=%h want all 0",
               req_ready_o, rsp_valid_o, push_o, pop_o, drop_o, rsp_status_o, rsp_data_o, rsp_id_o, drop_id_o, push_struct_o);
    end
    rst_i = 1'b0;
    tick();
    tick();
    checks++;
    if (req_ready_o !== 1'b1 || rsp_valid_o !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_release: got rdy=%b vld=%b want rdy=1 vld=0", req_ready_o, rsp_valid_o);
    end
  endtask

  task automatic test_push;
    send(2'b00, 16'd5, 16'd1);
    checks++;
    if ({push_o, pop_o, drop_o, req_ready_o, rsp_valid_o} !== 5'b10000 || push_struct_o !== {16'd5, 16'd1}) begin
      failures++;
      $display("[TB] FAIL push_issue: got strobes=%b%b%b rdy=%b vld=%b ps=%h want 100 0 0 ps=00050001",
               push_o, pop_o, drop_o, req_ready_o, rsp_valid_o, push_struct_o);
    end
    tick();
    checks++;
    if ({push_o, rsp_valid_o} !== 2'b00 || push_struct_o !== {16'd5, 16'd1}) begin
      failures++;
      $display("[TB] FAIL push_wait1: got push=%b vld=%b ps=%h want 0 0 ps=00050001", push_o, rsp_valid_o, push_struct_o);
    end
    tick();
    push_vld_i = 1'b1;
    checks++;
    if ({push_o, rsp_valid_o} !== 2'b00 || push_struct_o !== {16'd5, 16'd1}) begin
      failures++;
      $display("[TB] FAIL push_wait2: got push=%b vld=%b ps=%h want 0 0 ps=00050001", push_o, rsp_valid_o, push_struct_o);
    end
    tick();
    push_vld_i = 1'b0;
    checks++;
    if (rsp_valid_o !== 1'b1 || rsp_status_o !== 2'b00 || rsp_data_o !== 16'd0 || rsp_id_o !== 16'd0 || push_struct_o !== 32'd0) begin
      failures++;
      $display("[TB] FAIL push_resp: got vld=%b st=%b data=%h id=%h ps=%h want 1 00 0 0 0",
               rsp_valid_o, rsp_status_o, rsp_data_o, rsp_id_o, push_struct_o);
    end
    handshake();
    checks++;
    if (rsp_valid_o !== 1'b0 || req_ready_o !== 1'b1) begin
      failures++;
      $display("[TB] FAIL push_done: got vld=%b rdy=%b want 0 1", rsp_valid_o, req_ready_o);
    end
  endtask

  task automatic test_pop;
    peek_vld_i = 1'b1;
    send(2'b01, 16'd0, 16'd0);
    checks++;
    if ({push_o, pop_o, drop_o} !== 3'b010) begin
      failures++;
      $display("[TB] FAIL pop_issue: got strobes=%b%b%b want 010", push_o, pop_o, drop_o);
    end
    tick();
    pop_vld_i    = 1'b1;
    pop_struct_i = {16'd3, 16'd7};
    tick();
    pop_vld_i    = 1'b0;
    pop_struct_i = {16'hdead, 16'hbeef};
    checks++;
    if (rsp_valid_o !== 1'b1 || rsp_status_o !== 2'b00 || rsp_data_o !== 16'd3 || rsp_id_o !== 16'd7) begin
      failures++;
      $display("[TB] FAIL pop_resp: got vld=%b st=%b data=%h id=%h want 1 00 3 7",
               rsp_valid_o, rsp_status_o, rsp_data_o, rsp_id_o);
    end
    handshake();
    pop_struct_i = '0;
  endtask

  task automatic test_guards;
    peek_vld_i = 1'b0;
    send(2'b01, 16'd0, 16'd0);
    checks++;
    if (rsp_valid_o !== 1'b1 || rsp_status_o !== 2'b01 || rsp_data_o !== 16'd0 || {push_o, pop_o, drop_o} !== 3'b000) begin
      failures++;
      $display("[TB] FAIL empty_guard: got vld=%b st=%b data=%h strobes=%b%b%b want 1 01 0 000",
               rsp_valid_o, rsp_status_o, rsp_data_o, push_o, pop_o, drop_o);
    end
    handshake();
    full_i = 1'b1;
    send(2'b00, 16'd9, 16'd9);
    checks++;
    if (rsp_valid_o !== 1'b1 || rsp_status_o !== 2'b10 || {push_o, pop_o, drop_o} !== 3'b000 || push_struct_o !== 32'd0) begin
      failures++;
      $display("[TB] FAIL full_guard: got vld=%b st=%b strobes=%b%b%b ps=%h want 1 10 000 0",
               rsp_valid_o, rsp_status_o, push_o, pop_o, drop_o, push_struct_o);
    end
    handshake();
    full_i = 1'b0;
    send(2'b11, 16'd1, 16'd1);
    checks++;
    if (rsp_valid_o !== 1'b1 || rsp_status_o !== 2'b11 || {push_o, pop_o, drop_o} !== 3'b000) begin
      failures++;
      $display("[TB] FAIL illegal_op: got vld=%b st=%b strobes=%b%b%b want 1 11 000",
               rsp_valid_o, rsp_status_o, push_o, pop_o, drop_o);
    end
    handshake();
  endtask

  task automatic test_timeout;
    int bad;
    send(2'b10, 16'd0, 16'd4);
    checks++;
    if ({push_o, pop_o, drop_o} !== 3'b001 || drop_id_o !== 16'd4) begin
      failures++;
      $display("[TB] FAIL drop_issue: got strobes=%b%b%b dropid=%h want 001 4", push_o, pop_o, drop_o, drop_id_o);
    end
    bad = 0;
    for (int w = 0; w < TIMEOUT; w++) begin
      tick();
      if (drop_id_o !== 16'd4 || rsp_valid_o !== 1'b0 || drop_o !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("[TB] FAIL drop_wait_hold: got %0d bad WAIT cycles want 0", bad);
    end
    tick();
    checks++;
    if (rsp_valid_o !== 1'b1 || rsp_status_o !== 2'b11 || rsp_data_o !== 16'd0 || drop_id_o !== 16'd0) begin
      failures++;
      $display("[TB] FAIL drop_timeout: got vld=%b st=%b data=%h dropid=%h want 1 11 0 0",
               rsp_valid_o, rsp_status_o, rsp_data_o, drop_id_o);
    end
    drop_vld_i = 1'b1;
    tick();
    drop_vld_i = 1'b0;
    checks++;
    if (rsp_valid_o !== 1'b1 || rsp_status_o !== 2'b11) begin
      failures++;
      $display("[TB] FAIL late_vld: got vld=%b st=%b want 1 11", rsp_valid_o, rsp_status_o);
    end
    handshake();
    send(2'b00, 16'd2, 16'd8);
    tick();
    push_vld_i = 1'b1;
    tick();
    push_vld_i = 1'b0;
    checks++;
    if (rsp_valid_o !== 1'b1 || rsp_status_o !== 2'b00) begin
      failures++;
      $display("[TB] FAIL push_after_timeout: got vld=%b st=%b want 1 00", rsp_valid_o, rsp_status_o);
    end
    handshake();
  endtask

  task automatic test_ignore;
    peek_vld_i = 1'b1;
    send(2'b01, 16'd0, 16'd0);
    tick();
    push_vld_i = 1'b1;
    drop_vld_i = 1'b1;
    tick();
    push_vld_i = 1'b0;
    drop_vld_i = 1'b0;
    checks++;
    if (rsp_valid_o !== 1'b0) begin
      failures++;
      $display("[TB] FAIL wrong_vld_ignored: got vld=%b want 0", rsp_valid_o);
    end
    pop_vld_i    = 1'b1;
    pop_struct_i = {16'd9, 16'd2};
    tick();
    pop_vld_i = 1'b0;
    checks++;
    if (rsp_valid_o !== 1'b1 || rsp_status_o !== 2'b00 || rsp_data_o !== 16'd9 || rsp_id_o !== 16'd2) begin
      failures++;
      $display("[TB] FAIL pop_after_ignore: got vld=%b st=%b data=%h id=%h want 1 00 9 2",
               rsp_valid_o, rsp_status_o, rsp_data_o, rsp_id_o);
    end
    handshake();
  endtask

  task automatic test_backpressure;
    int bad;
    peek_vld_i = 1'b1;
    send(2'b01, 16'd0, 16'd0);
    tick();
    pop_vld_i    = 1'b1;
    pop_struct_i = {16'h1234, 16'habcd};
    tick();
    pop_vld_i = 1'b0;
    bad = 0;
    for (int c = 0; c < 5; c++) begin
      pop_struct_i = {16'(c), 16'(c)};
      if (rsp_valid_o !== 1'b1 || rsp_data_o !== 16'h1234 || rsp_id_o !== 16'habcd ||
          rsp_status_o !== 2'b00 || req_ready_o !== 1'b0) bad++;
      tick();
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("[TB] FAIL rsp_stall_stable: got %0d unstable cycles want 0", bad);
    end
    handshake();
    checks++;
    if (rsp_valid_o !== 1'b0 || req_ready_o !== 1'b1 || rsp_data_o !== 16'd0) begin
      failures++;
      $display("[TB] FAIL rsp_stall_release: got vld=%b rdy=%b data=%h want 0 1 0", rsp_valid_o, req_ready_o, rsp_data_o);
    end
    pop_struct_i = '0;
  endtask

  task automatic test_back_to_back;
    req_valid_i = 1'b1;
    req_op_i    = 2'b11;
    tick();
    rsp_ready_i = 1'b1;
    checks++;
    if (rsp_valid_o !== 1'b1 || req_ready_o !== 1'b0) begin
      failures++;
      $display("[TB] FAIL b2b_first: got vld=%b rdy=%b want 1 0", rsp_valid_o, req_ready_o);
    end
    tick();
    checks++;
    if (rsp_valid_o !== 1'b0 || req_ready_o !== 1'b1) begin
      failures++;
      $display("[TB] FAIL b2b_gap: got vld=%b rdy=%b want 0 1", rsp_valid_o, req_ready_o);
    end
    rsp_ready_i = 1'b0;
    tick();
    req_valid_i = 1'b0;
    checks++;
    if (rsp_valid_o !== 1'b1 || rsp_status_o !== 2'b11) begin
      failures++;
      $display("[TB] FAIL b2b_second: got vld=%b st=%b want 1 11", rsp_valid_o, rsp_status_o);
    end
    handshake();
    rsp_ready_i = 1'b1;
    tick();
    tick();
    checks++;
    if (rsp_valid_o !== 1'b0 || req_ready_o !== 1'b1) begin
      failures++;
      $display("[TB] FAIL idle_rsp_ready: got vld=%b rdy=%b want 0 1", rsp_valid_o, req_ready_o);
    end
    rsp_ready_i = 1'b0;
  endtask

  task automatic test_reset_in_wait;
    send(2'b00, 16'd6, 16'd3);
    tick();
    rst_i = 1'b1;
    tick();
    rst_i      = 1'b0;
    push_vld_i = 1'b1;
    checks++;
    if ({req_ready_o, rsp_valid_o, push_o, pop_o, drop_o} !== 5'b0 || push_struct_o !== 32'd0 || drop_id_o !== 16'd0) begin
      failures++;
      $display("[TB] FAIL reset_in_wait: got rdy=%b vld=%b strobes=%b%b%b ps=%h dropid=%h want all 0",
               req_ready_o, rsp_valid_o, push_o, pop_o, drop_o, push_struct_o, drop_id_o);
    end
    tick();
    push_vld_i = 1'b0;
    checks++;
    if (req_ready_o !== 1'b1 || rsp_valid_o !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_in_wait_release: got rdy=%b vld=%b want 1 0", req_ready_o, rsp_valid_o);
    end
  endtask

  initial begin
    rst_i        = 1'b1;
    req_valid_i  = 1'b0;
    req_op_i     = 2'b00;
    req_data_i   = '0;
    req_id_i     = '0;
    rsp_ready_i  = 1'b0;
    peek_vld_i   = 1'b0;
    peek_data_i  = 16'h0042;
    full_i       = 1'b0;
    push_vld_i   = 1'b0;
    pop_vld_i    = 1'b0;
    drop_vld_i   = 1'b0;
    pop_struct_i = '0;
    test_reset();
    test_push();
    test_pop();
    test_guards();
    test_timeout();
    test_ignore();
    test_backpressure();
    test_back_to_back();
    test_reset_in_wait();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
